shift_sequencer: RTL and testbench

- Synchronous controller that sequences a parallel-load / serial-shift register as a full-duplex serial link engine (SPI-mode-0-like), MSB first.
- Accepts a word over a valid/ready handshake and loads it.
- Generates a divided serial clock, shifts the word out while shifting received bits in, then presents the received word with a one-cycle valid pulse.
- Sits between the system-side data producer/consumer and the serial pins.

---
 rtl/shift_seq_pkg.sv | 11 +
 rtl/shift_sequencer_if.sv | 11 +
 rtl/shift_reg_sync.sv | 28 ++
 rtl/shift_sequencer.sv | 128 ++++++++++++
 tb/tb_shift_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and sizing helpers for the shift sequencer slice.
package shift_seq_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Counter width able to hold 0..range-1; never narrower than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// System-side word handshake between a producer/consumer and the shift sequencer.
interface shift_sequencer_if #(parameter int N = 8);
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [N-1:0] rx_data;
  logic         rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/shift_reg_sync.sv
// Parallel-load / serial-shift register, MSB out, new bits enter at the LSB.
module shift_reg_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic         serial_in,
  input  logic [N-1:0] parallel_in,
  output logic         serial_out,
  output logic [N-1:0] parallel_out
);
  logic [N-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= parallel_in;
    end else if (shift_en) begin
      q <= {q[N-2:0], serial_in};
    end
  end

  assign serial_out   = q[N-1];
  assign parallel_out = q;
endmodule

// File: rtl/shift_sequencer.sv
// Full-duplex serial link engine: loads a word, shifts it out MSB first on a
// divided sclk while sampling serial_in, then presents the received word.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_sequencer_if.slave      bus,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic                  sclk,
  output logic                  busy
);
  localparam int BIT_W = cnt_width(N);
  localparam int DIV_W = cnt_width(DIV);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] RISE_LAST  = DIV_W'(DIV / 2 - 1);
  localparam logic [DIV_W-1:0] HIGH_FIRST = DIV_W'(DIV / 2);

  if ((DIV % 2 != 0) || (DIV < 2) || (N < 2)) begin : g_param_guard
    $error("shift_sequencer: DIV must be even and >= 2, N must be >= 2");
  end

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic             sample, sample_en;
  logic             sclk_n;
  logic             load, shift_en, capture;
  logic [N-1:0]     q, shifted, rx_data_r;
  logic             unused_q_msb;

  shift_reg_sync #(.N(N)) u_shift_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .shift_en     (shift_en),
    .serial_in    (sample),
    .parallel_in  (bus.tx_data),
    .serial_out   (serial_out),
    .parallel_out (q)
  );

  // Word as it will look after the shift that ends the last bit.
  assign shifted      = {q[N-2:0], sample};
  assign unused_q_msb = q[N-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    load      = 1'b0;
    shift_en  = 1'b0;
    capture   = 1'b0;
    sample_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tx_valid && bus.tx_ready) begin
          load      = 1'b1;
          div_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        sample_en = (div_cnt == RISE_LAST);
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          shift_en  = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            capture   = 1'b1;
            state_n   = DONE;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // sclk is registered from the next divider phase so it lines up with div_cnt.
    sclk_n = (state_n == SHIFT) && (div_cnt_n >= HIGH_FIRST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sample    <= 1'b0;
      sclk      <= 1'b0;
      rx_data_r <= '0;
    end else begin
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      sclk    <= sclk_n;
      if (sample_en) begin
        sample <= serial_in;
      end
      if (capture) begin
        rx_data_r <= shifted;
      end
    end
  end

  assign bus.tx_ready = (state == IDLE) && !reset;
  assign bus.rx_valid = (state == DONE);
  assign bus.rx_data  = rx_data_r;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: transfer-level model compared every cycle, directed
// literal checks, and a timing sweep at two further N/DIV corners.
module tb_shift_sequencer;
  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int T   = N * DIV;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic loop_en = 1'b1;
  logic tie_bit = 1'b0;
  logic serial_in, serial_out, sclk, busy;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   rises = 0;
  int   acc_q[$];
  int   rxv_q[$];
  logic [N-1:0] rxd_q[$];
  logic so_q[$];

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  shift_sequencer_if #(.N(N)) bus ();

  shift_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .sclk       (sclk),
    .busy       (busy)
  );

  assign serial_in = loop_en ? serial_out : tie_bit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transfer model: k counts cycles since the accept edge (0 = idle).
  initial begin
    int k;
    int b;
    int ph;
    logic [N-1:0] m_word, m_acc, m_rx;
    logic m_so_idle;
    k = 0; m_word = '0; m_acc = '0; m_rx = '0; m_so_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        k = 0; m_rx = '0; m_so_idle = 1'b0;
        chk("m_rst_ready", bus.tx_ready, 1'b0);
        chk("m_rst_busy", busy, 1'b0);
        chk("m_rst_sclk", sclk, 1'b0);
        chk("m_rst_so", serial_out, 1'b0);
        chk("m_rst_rxv", bus.rx_valid, 1'b0);
        chk("m_rst_rxd", bus.rx_data, m_rx);
      end else if (k == 0) begin
        chk("m_idle_ready", bus.tx_ready, 1'b1);
        chk("m_idle_busy", busy, 1'b0);
        chk("m_idle_sclk", sclk, 1'b0);
        chk("m_idle_so", serial_out, m_so_idle);
        chk("m_idle_rxv", bus.rx_valid, 1'b0);
        chk("m_idle_rxd", bus.rx_data, m_rx);
        if (bus.tx_valid) begin
          k = 1; m_word = bus.tx_data; m_acc = '0;
        end
      end else if (k <= T) begin
        b  = (k - 1) / DIV;
        ph = (k - 1) % DIV;
        chk("m_sh_ready", bus.tx_ready, 1'b0);
        chk("m_sh_busy", busy, 1'b1);
        chk("m_sh_sclk", sclk, (ph >= DIV / 2));
        chk("m_sh_so", serial_out, m_word[N-1-b]);
        chk("m_sh_rxv", bus.rx_valid, 1'b0);
        chk("m_sh_rxd", bus.rx_data, m_rx);
        if (ph == DIV / 2 - 1) m_acc[N-1-b] = serial_in;
        k++;
      end else begin
        m_rx = m_acc; m_so_idle = m_acc[N-1];
        chk("m_done_ready", bus.tx_ready, 1'b0);
        chk("m_done_busy", busy, 1'b1);
        chk("m_done_sclk", sclk, 1'b0);
        chk("m_done_rxv", bus.rx_valid, 1'b1);
        chk("m_done_rxd", bus.rx_data, m_rx);
        chk("m_done_so", serial_out, m_so_idle);
        k = 0;
      end
    end
  end

  // Event recorder for the directed literal checks.
  initial begin
    logic sclk_prev;
    sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sclk && !sclk_prev) rises++;
        if (busy && !bus.rx_valid) so_q.push_back(serial_out);
        if (bus.rx_valid) begin
          rxv_q.push_back(cyc);
          rxd_q.push_back(bus.rx_data);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          acc_q.push_back(cyc);
          rises = 0;
          so_q.delete();
        end
      end
      sclk_prev = sclk;
    end
  end

  task automatic wait_acc(input int n);
    int g;
    g = 0;
    while (acc_q.size() < n && g < 400) begin
      @(negedge clk); #1; g++;
    end
    chk("acc_wait", (acc_q.size() >= n), 1'b1);
  endtask

  task automatic wait_rx(input int n);
    int g;
    g = 0;
    while (rxv_q.size() < n && g < 400) begin
      @(negedge clk); #1; g++;
    end
    chk("rx_wait", (rxv_q.size() >= n), 1'b1);
  endtask

  task automatic xfer(input logic [N-1:0] w);
    int a0;
    int r0;
    a0 = acc_q.size(); r0 = rxv_q.size();
    @(posedge clk); #1;
    bus.tx_data = w; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    wait_rx(r0 + 1);
  endtask

  task automatic check_xfer(input string nm, input logic [N-1:0] exp_rx, input logic [N-1:0] exp_tx);
    logic [N-1:0] so_word;
    logic stable;
    so_word = '0; stable = 1'b1;
    if (rxv_q.size() > 0 && acc_q.size() > 0) begin
      chk({nm, "_rx"}, rxd_q[rxd_q.size()-1], exp_rx);
      chk({nm, "_latency"}, rxv_q[rxv_q.size()-1] - acc_q[acc_q.size()-1], T + 1);
    end
    chk({nm, "_sclk_rises"}, rises, N);
    chk({nm, "_so_len"}, so_q.size(), T);
    if (so_q.size() == T) begin
      for (int i = 0; i < N; i++) begin
        so_word[N-1-i] = so_q[i*DIV];
        for (int j = 1; j < DIV; j++)
          if (so_q[i*DIV+j] !== so_q[i*DIV]) stable = 1'b0;
      end
      chk({nm, "_so_bits"}, so_word, exp_tx);
      chk({nm, "_so_stable"}, stable, 1'b1);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int NN = (g == 0) ? 2 : 16;
    localparam int DD = (g == 0) ? 2 : 8;
    logic s_rst = 1'b1;
    logic done  = 1'b0;
    logic s_so, s_sclk, s_busy;

    shift_sequencer_if #(.N(NN)) s_bus ();

    shift_sequencer #(.N(NN), .DIV(DD)) s_dut (
      .clk        (clk),
      .reset      (s_rst),
      .bus        (s_bus),
      .serial_in  (s_so),
      .serial_out (s_so),
      .sclk       (s_sclk),
      .busy       (s_busy)
    );

    initial begin
      logic [NN-1:0] w, got;
      int n_busy, n_hi, n_rise, n_rxv, gd;
      logic prev;
      s_bus.tx_valid = 1'b0; s_bus.tx_data = '0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
        w = NN'($urandom);
        @(posedge clk); #1;
        s_bus.tx_data = w; s_bus.tx_valid = 1'b1;
        chk($sformatf("sw%0d_ready", NN), s_bus.tx_ready, 1'b1);
        @(posedge clk); #1;
        s_bus.tx_valid = 1'b0;
        n_busy = 0; n_hi = 0; n_rise = 0; n_rxv = 0; gd = 0; prev = 1'b0; got = '0;
        do begin
          @(negedge clk);
          gd++;
          if (s_busy) n_busy++;
          if (s_sclk) n_hi++;
          if (s_sclk && !prev) n_rise++;
          prev = s_sclk;
          if (s_bus.rx_valid) begin
            n_rxv++; got = s_bus.rx_data;
          end
        end while ((s_busy || gd < 2) && gd < 1000);
        chk($sformatf("sw%0d_busy_len", NN), n_busy, NN * DD + 1);
        chk($sformatf("sw%0d_sclk_high", NN), n_hi, NN * DD / 2);
        chk($sformatf("sw%0d_sclk_rises", NN), n_rise, NN);
        chk($sformatf("sw%0d_rxv_width", NN), n_rxv, 1);
        chk($sformatf("sw%0d_rx", NN), got, w);
      end
      done = 1'b1;
    end
  end

  initial begin
    int a0;
    int r0;
    int rel;
    int g;
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.tx_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rxd", bus.rx_data, 8'h00);
    reset = 1'b0;
    #1 chk("ready_after_release", bus.tx_ready, 1'b1);

    xfer(8'hA5);
    check_xfer("loop_a5", 8'hA5, 8'hA5);

    @(posedge clk); #1 loop_en = 1'b0; tie_bit = 1'b1;
    xfer(8'h00);
    check_xfer("tie1", 8'hFF, 8'h00);
    @(posedge clk); #1 tie_bit = 1'b0;
    xfer(8'hFF);
    check_xfer("tie0", 8'h00, 8'hFF);
    @(posedge clk); #1 loop_en = 1'b1;

    // Back-to-back with tx_valid held through both transfers.
    a0 = acc_q.size(); r0 = rxv_q.size();
    @(posedge clk); #1 bus.tx_data = 8'h3C; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    @(posedge clk); #1 bus.tx_data = 8'hC3;
    wait_acc(a0 + 2);
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    wait_rx(r0 + 2);
    if (acc_q.size() >= a0 + 2 && rxv_q.size() >= r0 + 2) begin
      chk("b2b_gap", acc_q[a0+1] - acc_q[a0], T + 2);
      chk("b2b_rx0", rxd_q[r0], 8'h3C);
      chk("b2b_rx1", rxd_q[r0+1], 8'hC3);
    end
    chk("b2b_accepts", acc_q.size() - a0, 2);

    // Abort during bit 3 of 0x5A, in the sclk-high half of that bit.
    a0 = acc_q.size(); r0 = rxv_q.size();
    @(posedge clk); #1 bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    chk("pre_abort_sclk", sclk, 1'b1);
    chk("pre_abort_busy", busy, 1'b1);
    chk("pre_abort_so", serial_out, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_so", serial_out, 1'b0);
    chk("abort_ready", bus.tx_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (T + 5) @(posedge clk);
    #1 chk("abort_no_rxv", rxv_q.size(), r0);
    xfer(8'h81);
    check_xfer("after_abort", 8'h81, 8'h81);

    // Reset released while tx_valid is already high.
    a0 = acc_q.size();
    @(posedge clk); #1 reset = 1'b1; bus.tx_data = 8'h66; bus.tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstval_ready", bus.tx_ready, 1'b0);
    chk("rstval_busy", busy, 1'b0);
    chk("rstval_no_acc", acc_q.size(), a0);
    reset = 1'b0;
    rel = cyc;
    wait_acc(a0 + 1);
    if (acc_q.size() > a0) chk("rstval_acc_cycle", acc_q[a0], rel);
    r0 = rxv_q.size();
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    wait_rx(r0 + 1);
    check_xfer("rstval", 8'h66, 8'h66);

    g = 0;
    while (!(g_sweep[0].done && g_sweep[1].done) && g < 5000) begin
      @(posedge clk); g++;
    end
    chk("sweep_finished", (g_sweep[0].done && g_sweep[1].done), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
